// File: rtl/booth_multiplier_param.sv
// Multi-cycle signed/unsigned Booth multiplier with start/ready/done handshake.
// Define BOOTH_RADIX4_EN for radix-4 modified Booth recoding; otherwise radix-2.
module booth_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ready,
  output logic                 done
);

`ifdef BOOTH_RADIX4_EN
  localparam int SH   = 2;
  localparam int ITER = WIDTH / 2 + 1;
`else
  localparam int SH   = 1;
  localparam int ITER = WIDTH + 1;
`endif
  // Multiplier bits consumed in total; the accumulator keeps headroom for +-2A.
  localparam int MW = ITER * SH;
  localparam int AW = WIDTH + 4;
  localparam int PW = AW + MW + 1;
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       a_q, a_d;
  logic [PW-1:0]       p_q, p_d;
  logic [2*WIDTH-1:0]  product_q, product_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  logic [AW-1:0]       addend_s;
  logic [AW-1:0]       upper_s;
  logic [PW-1:0]       sum_s;
  logic [PW-1:0]       shifted_s;

  always_comb begin
    addend_s = '0;
`ifdef BOOTH_RADIX4_EN
    case (p_q[2:0])
      3'b001, 3'b010: addend_s = a_q;
      3'b011:         addend_s = {a_q[AW-2:0], 1'b0};
      3'b100:         addend_s = -{a_q[AW-2:0], 1'b0};
      3'b101, 3'b110: addend_s = -a_q;
      default:        addend_s = '0;
    endcase
`else
    case (p_q[1:0])
      2'b01:   addend_s = a_q;
      2'b10:   addend_s = -a_q;
      default: addend_s = '0;
    endcase
`endif
    upper_s   = p_q[PW-1 -: AW] + addend_s;
    sum_s     = {upper_s, p_q[MW:0]};
    shifted_s = $signed(sum_s) >>> SH;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    p_d       = p_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Extension fill is the sign bit for signed operands, zero otherwise.
          a_d     = tc ? {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand}
                       : {{(AW-WIDTH){1'b0}}, multiplicand};
          p_d     = tc ? {{AW{1'b0}}, {(MW-WIDTH){multiplier[WIDTH-1]}}, multiplier, 1'b0}
                       : {{AW{1'b0}}, {(MW-WIDTH){1'b0}}, multiplier, 1'b0};
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        p_d   = shifted_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        product_d = p_q[2*WIDTH:1];
        done_d    = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      p_q       <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      p_q       <= p_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign ready   = ready_q;
  assign done    = done_q;

endmodule
